// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hilo_pkg
// Purpose  : Shared definitions for the HI/LO multiply/divide unit:
//            HiLoOp encodings, default datapath width, FSM state
//            encoding and the divide-by-zero quotient constant.
// Revision : 1.0 - initial release
// ============================================================================
package hilo_pkg;

    localparam int HILO_WIDTH = 32;

    // Quotient written to LO when the divisor is zero
    localparam logic [31:0] HILO_DIVZERO_LO = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        HILO_NONE = 3'b000,
        HILO_LOAD = 3'b001,
        HILO_MADD = 3'b010,
        HILO_MSUB = 3'b011,
        HILO_MTHI = 3'b100,
        HILO_MTLO = 3'b101,
        HILO_DIV  = 3'b110,
        HILO_DIVU = 3'b111
    } hilo_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIX  = 2'd2
    } hilo_state_e;

endpackage : hilo_pkg
`default_nettype wire

// File: rtl/hilo_muldiv_unit_div_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : div_iter_core
// Purpose  : Unsigned restoring divider datapath. i_start loads the
//            operands; each i_step cycle retires one quotient bit. o_done
//            flags the final step, after which o_quotient/o_remainder hold
//            the magnitude results.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter_core
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_done
);

    localparam int              CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // One extra bit holds the shifted partial remainder, which can reach 2*divisor-1
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // Next-state logic: operand load on start, one shift/subtract per step
    always_comb begin
        w_shift = {rem_q, quo_q[WIDTH-1]};
        w_diff  = w_shift - {1'b0, dvs_q};
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        if (i_start) begin
            rem_d = '0;
            quo_d = i_dividend;
            dvs_d = i_divisor;
            cnt_d = '0;
        end else if (i_step) begin
            if (!w_diff[WIDTH]) begin
                rem_d = w_diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = w_shift[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Datapath registers; reset discards any in-flight divide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_quotient  = quo_q;
    assign o_remainder = rem_q;
    assign o_done      = i_step && (cnt_q == C_LAST);

endmodule : div_iter_core
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_unit
// Purpose  : HI/LO register pair for the EX stage. Captures ALU products,
//            performs madd/msub/mthi/mtlo in one cycle and runs div/divu
//            through an iterative restoring divider (33 busy cycles),
//            stalling the pipeline while a divide is in flight.
// Options  : HILO_BYPASS_EN - Hi/Lo outputs forward the next-state value of
//            single-cycle ops in the same cycle they are issued.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [2:0]       HiLoOp,
    input  logic [WIDTH-1:0] ProdLo,
    input  logic [WIDTH-1:0] ProdHi,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ReadHiLo,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Stall
);

    localparam int MSB = WIDTH - 1;

    hilo_state_e      state_q, state_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             neg_q_q, neg_q_d;   // quotient needs negation
    logic             neg_r_q, neg_r_d;   // remainder needs negation
    logic             dz_q, dz_d;         // divisor was zero
    logic [WIDTH-1:0] a_orig_q, a_orig_d; // dividend kept for the dz result

    logic             w_single_wr;
    logic [WIDTH-1:0] w_single_hi;
    logic [WIDTH-1:0] w_single_lo;
    logic [2*WIDTH-1:0] w_acc;
    logic             w_start;
    logic             w_step;
    logic             w_is_signed;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic             w_done;

    div_iter_core #(
        .WIDTH (WIDTH)
    ) u_div_iter_core (
        .clk         (Clk),
        .rst         (Reset),
        .i_start     (w_start),
        .i_step      (w_step),
        .i_dividend  (w_a_mag),
        .i_divisor   (w_b_mag),
        .o_quotient  (w_quo),
        .o_remainder (w_rem),
        .o_done      (w_done)
    );

    // Single-cycle op results; only accepted while no divide is running
    always_comb begin
        w_single_wr = 1'b0;
        w_single_hi = hi_q;
        w_single_lo = lo_q;
        w_acc       = '0;
        if (!busy_q) begin
            case (HiLoOp)
                HILO_LOAD: begin
                    w_single_wr = 1'b1;
                    w_single_hi = ProdHi;
                    w_single_lo = ProdLo;
                end
                HILO_MADD: begin
                    w_single_wr = 1'b1;
                    w_acc       = {hi_q, lo_q} + {ProdHi, ProdLo};
                    {w_single_hi, w_single_lo} = w_acc;
                end
                HILO_MSUB: begin
                    w_single_wr = 1'b1;
                    w_acc       = {hi_q, lo_q} - {ProdHi, ProdLo};
                    {w_single_hi, w_single_lo} = w_acc;
                end
                HILO_MTHI: begin
                    w_single_wr = 1'b1;
                    w_single_hi = A;
                end
                HILO_MTLO: begin
                    w_single_wr = 1'b1;
                    w_single_lo = A;
                end
                default: ;
            endcase
        end
    end

    // Divide FSM next state, operand sign handling and HI/LO write selection
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        hi_d        = w_single_wr ? w_single_hi : hi_q;
        lo_d        = w_single_wr ? w_single_lo : lo_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        dz_d        = dz_q;
        a_orig_d    = a_orig_q;
        w_start     = 1'b0;
        w_step      = 1'b0;
        w_is_signed = (HiLoOp == HILO_DIV);
        w_a_mag     = (w_is_signed && A[MSB]) ? (~A + 1'b1) : A;
        w_b_mag     = (w_is_signed && B[MSB]) ? (~B + 1'b1) : B;
        case (state_q)
            ST_IDLE: begin
                if (HiLoOp == HILO_DIV || HiLoOp == HILO_DIVU) begin
                    w_start  = 1'b1;
                    state_d  = ST_DIV;
                    busy_d   = 1'b1;
                    neg_q_d  = w_is_signed && (A[MSB] ^ B[MSB]);
                    neg_r_d  = w_is_signed && A[MSB];
                    dz_d     = (B == '0);
                    a_orig_d = A;
                end
            end
            ST_DIV: begin
                w_step = 1'b1;
                if (w_done) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (dz_q) begin
                    lo_d = WIDTH'($signed(HILO_DIVZERO_LO));
                    hi_d = a_orig_q;
                end else begin
                    lo_d = neg_q_q ? (~w_quo + 1'b1) : w_quo;
                    hi_d = neg_r_q ? (~w_rem + 1'b1) : w_rem;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM and HI/LO registers; reset clears everything at once
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
            a_orig_q <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            dz_q     <= dz_d;
            a_orig_q <= a_orig_d;
        end
    end

`ifdef HILO_BYPASS_EN
    // Forward single-cycle results so a same-cycle mfhi/mflo sees them
    assign Hi = w_single_wr ? w_single_hi : hi_q;
    assign Lo = w_single_wr ? w_single_lo : lo_q;
`else
    assign Hi = hi_q;
    assign Lo = lo_q;
`endif

    assign Busy  = busy_q;
    assign Stall = busy_q && (ReadHiLo || (HiLoOp != HILO_NONE));

endmodule : hilo_muldiv_unit
`default_nettype wire

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- HI/LO register unit that consumes the 64-bit product emitted by the 32-bit ALU (ALUResultHi:ALUResult) and holds it for mfhi/mflo.
- Also implements madd/msub accumulation, mthi/mtlo, and an iterative restoring divider for div/divu.
- Sits beside the ALU in the EX stage. Raises Stall to the hazard unit while a divide is in flight.

Parameters:
- WIDTH, 32, datapath width. The divider runs WIDTH iterations.

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- HiLoOp  in  3  000 none, 001 load product, 010 madd, 011 msub, 100 mthi, 101 mtlo, 110 div, 111 divu
- ProdLo  in  WIDTH  ALU product low word (ALUResult)
- ProdHi  in  WIDTH  ALU product high word (ALUResultHi)
- A  in  WIDTH  rs operand (dividend; mthi/mtlo source)
- B  in  WIDTH  rt operand (divisor)
- ReadHiLo  in  1  mfhi/mflo present in EX this cycle
- Hi  out  WIDTH  HI register
- Lo  out  WIDTH  LO register
- Busy  out  1  divide in progress
- Stall  out  1  Busy and (ReadHiLo or HiLoOp != 000)

Behaviour:
- Reset (async, any time, including mid-divide):
  - Hi=0, Lo=0, Busy=0, state=IDLE, iteration counter=0.
  - An in-flight divide is discarded.
- Single-cycle ops, accepted only when Busy=0; the result is visible on Hi/Lo after the same edge:
  - 001: Hi<=ProdHi, Lo<=ProdLo.
  - 010: {Hi,Lo} <= {Hi,Lo} + {ProdHi,ProdLo}, modulo 2^64.
  - 011: {Hi,Lo} <= {Hi,Lo} - {ProdHi,ProdLo}, modulo 2^64.
  - 100: Hi<=A, Lo unchanged.
  - 101: Lo<=A, Hi unchanged.
- FSM states: IDLE, DIV, FIX.
  - IDLE to DIV when HiLoOp is 110 or 111 at edge E0. Latch:
    - signedness;
    - |A| and |B| (magnitudes for div, raw values for divu);
    - quotient sign = A[31]^B[31] (div only);
    - remainder sign = A[31] (div only);
    - divide-by-zero flag = (B==0).
    - Busy=1 after E0.
  - DIV performs one restoring iteration per edge, E1..E32 (counter 0..WIDTH-1), then goes to FIX.
  - FIX, at edge E33:
    - writes Lo=quotient and Hi=remainder, with sign correction applied;
    - goes to IDLE with Busy=0.
    - Total: Busy high for exactly 33 cycles. The first dependent mfhi/mflo reads the new values in the cycle after Busy falls.
- Divide by zero, both signed and unsigned:
  - full 33-cycle latency is still taken;
  - FIX writes Lo=32'hFFFFFFFF, Hi=A (original, unmodified).
- Signed overflow (0x80000000 / -1): Lo=0x80000000, Hi=0. No trap.
- Remainder takes the sign of the dividend. Quotient truncates toward zero.
- Any HiLoOp != 000 while Busy=1:
  - ignored (no state change);
  - Stall=1, so the pipeline must hold the op and re-present it.
- ReadHiLo while Busy=1: Stall=1. Hi/Lo continue to show the pre-divide values.
- Hi/Lo are never modified by DIV-state iterations. Only FIX writes them.
- Stall is purely combinational from Busy, ReadHiLo and HiLoOp.

Optional Feature:
- Macro: HILO_BYPASS_EN.
- When defined:
  - Hi/Lo outputs are combinational next-state values for single-cycle ops (001–101), so an mfhi in the same cycle as mthi/madd sees the new value.
  - Divide results are still visible only after FIX.
- When undefined: Hi/Lo are the registered values only, and new values appear one cycle after the write edge.

Decomposition:
- Shared package hilo_pkg holds:
  - HiLoOp encodings (HILO_NONE … HILO_DIVU);
  - WIDTH default;
  - divide-by-zero result constant 32'hFFFFFFFF.
- One sub-module, div_iter_core:
  - restoring divider datapath (remainder/quotient shift registers, subtract-compare, counter);
  - driven by start/done.
- Top level holds the FSM, sign handling and HI/LO registers.

Test Plan:
- Reset then HiLoOp=001, ProdHi=0x00000001, ProdLo=0x80000000 -> next cycle Hi=0x00000001, Lo=0x80000000, Busy=0.
- Hi:Lo=0x00000000_FFFFFFFF, madd with product 0x00000000_00000001 -> Hi=0x00000001, Lo=0x00000000. Then msub with the same product -> back to 0x00000000_FFFFFFFF.
- div A=-7 (0xFFFFFFF9), B=2:
  - Busy high exactly 33 cycles;
  - then Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1).
  - divu with the same operands -> Lo=0x7FFFFFFC, Hi=0x00000001.
- divu A=0x1234, B=0 -> after 33 cycles Lo=0xFFFFFFFF, Hi=0x00001234. Signed div 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- During a div:
  - ReadHiLo=1 and HiLoOp=100 -> Stall=1 every cycle, Hi unchanged.
  - After Busy drops, re-presented mthi A=0xCAFEF00D -> Hi=0xCAFEF00D.
- Assert Reset at cycle 10 of a div -> Hi=Lo=0 and Busy=0 immediately (asynchronously). No later FIX write occurs.
